final_spin_rf_readout: RTL and testbench
========================================

// Module: final_spin_rf_readout
// PURPOSE
//  Reads final 50-bit spin words from the final-spin register file (addr 0..run_count-1).
//  Serialises each word onto the 8-bit GPIO output with a valid/ready handshake.
//  This is the transmit-side mirror of the GPIO byte format used to load initial spins:
//  7 bytes per word, MSB first, last byte carries 2 bits.
//  Sits between the system control registers, the final-spin RF macro and the GPIO output pads.
// PARAMETERS
//  none (word width 50, address width 7 and byte width 8 are fixed by the RF macro and the GPIO)
// PORTS
//  i_clk                    in   1   system clock; single clock domain
//  i_rst                    in   1   synchronous reset, active-high
//  conf_sys_ctrl_reg_READOUT in  1   level; high requests/holds readout; low aborts or acknowledges done
//  conf_sys_ctrl_reg_RESET  in   1   rising edge (internally registered) acts as a soft reset
//  conf_reg_total_run_count in   8   number of words to send; values >128 saturate to 128
//  final_spin_rf_q          in   50  RF read data, valid 1 cycle after ceb=0
//  out_GPIO_ready           in   1   downstream accepts byte when high with out_GPIO_valid
//  final_spin_rf_a          out  7   RF read address
//  final_spin_rf_ceb        out  1   RF read enable, active-low, one-cycle pulse per word
//  out_GPIO                 out  8   byte data
//  out_GPIO_valid           out  1   byte valid
//  readout_done             out  1   high in DONE state
//  readout_word_cnt         out  8   number of words fully sent
// BEHAVIOUR
//  Reset (i_rst or RESET rising edge): state=IDLE, out_GPIO=0, out_GPIO_valid=0, final_spin_rf_ceb=1,
//   final_spin_rf_a=0, readout_done=0, readout_word_cnt=0. Soft reset has lower priority than i_rst.
//  FSM: IDLE -> RD -> CAP -> SEND -> (RD | DONE); DONE -> IDLE.
//   IDLE: when READOUT=1: if count==0 go to DONE, else go to RD with addr=0.
//   RD: ceb=0 for exactly this cycle at addr a.
//   CAP: capture final_spin_rf_q into a 56-bit shift register, clear the byte index, go to SEND.
//   SEND: out_GPIO_valid=1. Bytes are sent in this order:
//    [49:42], [41:34], [33:26], [25:18], [17:10], [9:2], {6'b0, [1:0]}.
//    A byte transfers on valid&&ready. out_GPIO is held stable while valid&&!ready.
//    After the last byte transfers:
//     readout_word_cnt increments;
//     if a==count-1 go to DONE, else a++ and go to RD.
//    Valid drops during the RD/CAP cycles.
//   DONE: readout_done=1, ceb=1, valid=0. Stays until READOUT=0, then go to IDLE and clear done/cnt.
//  Latency: READOUT sampled high in IDLE at edge N gives ceb=0 in cycle N+1 and byte0 valid in cycle N+3.
//   With ready tied high, each word takes 9 cycles.
//  Abort: READOUT=0 in RD/CAP/SEND goes to IDLE on the next edge.
//   valid drops immediately, with no partial-word completion; readout_word_cnt is cleared.
//  Simultaneous soft reset and READOUT=1: soft reset wins, and the FSM restarts from IDLE next cycle.
//  Count arithmetic uses 8 bits. Address compares use the saturated count (min(count,128)).
//   The address never wraps.
// CONFIGURATION
//  READOUT_CHECKSUM_EN defined:
//   After byte 6, an 8th byte is sent, equal to the XOR of bytes 0..6 of the word.
//   Words take 8 transfers, and readout_word_cnt increments only after the checksum byte.
//  Undefined: exactly 7 bytes per word and no checksum logic.
// TESTING
//  T1: count=2, RF[0]=50'h3_FFFF_FFFF_FFFF, RF[1]=50'h0_0000_0000_0001, ready=1
//   -> bytes FF,FF,FF,FF,FF,FF,03, 00,00,00,00,00,00,01.
//   -> done=1, cnt=2, ceb low exactly 2 cycles.
//  T2: count=1, word 50'h2_AAAA_AAAA_AAAA, ready toggling 1-0-0-1
//   -> each byte held stable while valid&&!ready, no byte lost or duplicated.
//   -> sequence AA,AA,AA,AA,AA,AA,02.
//  T3: count=0, READOUT=1 -> DONE next cycle, no ceb pulse, valid never high.
//   -> READOUT=0 -> done clears next cycle.
//  T4: count=3, READOUT dropped after 10 byte transfers -> valid=0 next cycle, state IDLE, cnt=0.
//   -> re-assert -> restarts at addr 0.
//  T5: RESET rising edge mid-SEND of word 5, then i_rst for 1 cycle mid-RD
//   -> all outputs return to reset values.
//  T6: count=200 -> exactly 128 words read (addr 0..127), cnt=128.
//   With READOUT_CHECKSUM_EN: T1 word0 checksum byte = FF^FF^FF^FF^FF^FF^03 = 03.

Source files
------------

// File: rtl/final_spin_rf_readout.sv
// Final-spin register file readout: serialises 50-bit words onto the 8-bit GPIO with valid/ready.
// Optional READOUT_CHECKSUM_EN appends an XOR checksum byte after each word.
module final_spin_rf_readout (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic        conf_sys_ctrl_reg_READOUT,
  input  logic        conf_sys_ctrl_reg_RESET,
  input  logic [7:0]  conf_reg_total_run_count,
  input  logic [49:0] final_spin_rf_q,
  input  logic        out_GPIO_ready,
  output logic [6:0]  final_spin_rf_a,
  output logic        final_spin_rf_ceb,
  output logic [7:0]  out_GPIO,
  output logic        out_GPIO_valid,
  output logic        readout_done,
  output logic [7:0]  readout_word_cnt
);

`ifdef READOUT_CHECKSUM_EN
  localparam logic [2:0] LAST_BYTE = 3'd7;
`else
  localparam logic [2:0] LAST_BYTE = 3'd6;
`endif

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_RD   = 3'd1,
    S_CAP  = 3'd2,
    S_SEND = 3'd3,
    S_DONE = 3'd4
  } state_t;

  // Lay the word out so every byte, including the 2-bit tail, is a plain top-byte shift.
  function automatic logic [55:0] pack_word(input logic [49:0] w);
    return {w[49:2], 6'b000000, w[1:0]};
  endfunction

  function automatic logic [7:0] xor_bytes(input logic [55:0] p);
    return p[55:48] ^ p[47:40] ^ p[39:32] ^ p[31:24] ^ p[23:16] ^ p[15:8] ^ p[7:0];
  endfunction

  state_t      state_q, state_d;
  logic [6:0]  a_q, a_d;
  logic        ceb_q, ceb_d;
  logic [7:0]  gpio_q, gpio_d;
  logic        valid_q, valid_d;
  logic        done_q, done_d;
  logic [7:0]  cnt_q, cnt_d;
  logic [55:0] sr_q, sr_d;
  logic [2:0]  idx_q, idx_d;
  logic        soft_rst_prev_q, soft_rst_prev_d;
`ifdef READOUT_CHECKSUM_EN
  logic [7:0]  chk_q, chk_d;
`endif

  logic        soft_rst_s;
  logic [7:0]  cnt_sat_s;
  logic        last_addr_s;
  logic [55:0] packed_s;

  // Next-state and registered-output computation
  always_comb begin
    state_d         = state_q;
    a_d             = a_q;
    ceb_d           = 1'b1;
    gpio_d          = gpio_q;
    valid_d         = valid_q;
    done_d          = done_q;
    cnt_d           = cnt_q;
    sr_d            = sr_q;
    idx_d           = idx_q;
    soft_rst_prev_d = conf_sys_ctrl_reg_RESET;
`ifdef READOUT_CHECKSUM_EN
    chk_d           = chk_q;
`endif
    soft_rst_s  = conf_sys_ctrl_reg_RESET && !soft_rst_prev_q;
    cnt_sat_s   = (conf_reg_total_run_count > 8'd128) ? 8'd128 : conf_reg_total_run_count;
    last_addr_s = ({1'b0, a_q} == (cnt_sat_s - 8'd1));
    packed_s    = pack_word(final_spin_rf_q);

    case (state_q)
      S_IDLE: begin
        valid_d = 1'b0;
        done_d  = 1'b0;
        if (conf_sys_ctrl_reg_READOUT) begin
          if (cnt_sat_s == 8'd0) begin
            state_d = S_DONE;
            done_d  = 1'b1;
          end else begin
            state_d = S_RD;
            a_d     = 7'd0;
            ceb_d   = 1'b0;
          end
        end else begin
          state_d = S_IDLE;
        end
      end
      S_RD, S_CAP, S_SEND: begin
        if (!conf_sys_ctrl_reg_READOUT) begin
          // Abort drops the word in flight; nothing partial is completed.
          state_d = S_IDLE;
          valid_d = 1'b0;
          gpio_d  = 8'h00;
          a_d     = 7'd0;
          cnt_d   = 8'd0;
          done_d  = 1'b0;
        end else if (state_q == S_RD) begin
          state_d = S_CAP;
        end else if (state_q == S_CAP) begin
          sr_d    = packed_s;
          idx_d   = 3'd0;
          gpio_d  = packed_s[55:48];
          valid_d = 1'b1;
          state_d = S_SEND;
`ifdef READOUT_CHECKSUM_EN
          chk_d   = xor_bytes(packed_s);
`endif
        end else if (out_GPIO_ready) begin
          if (idx_q == LAST_BYTE) begin
            cnt_d   = cnt_q + 8'd1;
            valid_d = 1'b0;
            if (last_addr_s) begin
              state_d = S_DONE;
              done_d  = 1'b1;
            end else begin
              a_d     = a_q + 7'd1;
              ceb_d   = 1'b0;
              state_d = S_RD;
            end
          end else begin
            idx_d  = idx_q + 3'd1;
            sr_d   = {sr_q[47:0], 8'h00};
            gpio_d = sr_q[47:40];
`ifdef READOUT_CHECKSUM_EN
            if (idx_q == 3'd6) begin
              gpio_d = chk_q;
            end else begin
              gpio_d = sr_q[47:40];
            end
`endif
          end
        end else begin
          state_d = S_SEND;
        end
      end
      S_DONE: begin
        valid_d = 1'b0;
        done_d  = 1'b1;
        if (!conf_sys_ctrl_reg_READOUT) begin
          state_d = S_IDLE;
          done_d  = 1'b0;
          cnt_d   = 8'd0;
        end else begin
          state_d = S_DONE;
        end
      end
      default: begin
        state_d = S_IDLE;
        valid_d = 1'b0;
        done_d  = 1'b0;
      end
    endcase
  end

  // State and output registers; hard reset outranks the RESET-bit edge
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q         <= S_IDLE;
      a_q             <= 7'd0;
      ceb_q           <= 1'b1;
      gpio_q          <= 8'h00;
      valid_q         <= 1'b0;
      done_q          <= 1'b0;
      cnt_q           <= 8'd0;
      sr_q            <= 56'd0;
      idx_q           <= 3'd0;
      soft_rst_prev_q <= 1'b0;
`ifdef READOUT_CHECKSUM_EN
      chk_q           <= 8'h00;
`endif
    end else begin
      soft_rst_prev_q <= soft_rst_prev_d;
      if (soft_rst_s) begin
        state_q <= S_IDLE;
        a_q     <= 7'd0;
        ceb_q   <= 1'b1;
        gpio_q  <= 8'h00;
        valid_q <= 1'b0;
        done_q  <= 1'b0;
        cnt_q   <= 8'd0;
        sr_q    <= 56'd0;
        idx_q   <= 3'd0;
`ifdef READOUT_CHECKSUM_EN
        chk_q   <= 8'h00;
`endif
      end else begin
        state_q <= state_d;
        a_q     <= a_d;
        ceb_q   <= ceb_d;
        gpio_q  <= gpio_d;
        valid_q <= valid_d;
        done_q  <= done_d;
        cnt_q   <= cnt_d;
        sr_q    <= sr_d;
        idx_q   <= idx_d;
`ifdef READOUT_CHECKSUM_EN
        chk_q   <= chk_d;
`endif
      end
    end
  end

  assign final_spin_rf_a   = a_q;
  assign final_spin_rf_ceb = ceb_q;
  assign out_GPIO          = gpio_q;
  assign out_GPIO_valid    = valid_q;
  assign readout_done      = done_q;
  assign readout_word_cnt  = cnt_q;

endmodule

// File: tb/tb_final_spin_rf_readout.sv
// Directed bench for final_spin_rf_readout with a one-cycle-latency RF model and a GPIO monitor.
module tb_final_spin_rf_readout;

`ifdef READOUT_CHECKSUM_EN
  localparam int BPW = 8;
`else
  localparam int BPW = 7;
`endif

  logic        i_clk = 1'b0;
  logic        i_rst;
  logic        readout;
  logic        soft_reset;
  logic [7:0]  run_count;
  logic [49:0] rf_q;
  logic        gpio_ready;
  logic [6:0]  rf_a;
  logic        rf_ceb;
  logic [7:0]  gpio;
  logic        gpio_valid;
  logic        done;
  logic [7:0]  word_cnt;

  int errors = 0;
  int checks = 0;

  logic [49:0] rf_mem [0:127];
  logic [7:0]  bytes_q [$];
  logic [6:0]  addr_q [$];
  int          ceb_cnt = 0;
  int          valid_cnt = 0;
  int          stall_err = 0;
  logic        prev_stall = 1'b0;
  logic [7:0]  prev_byte = 8'h00;

  final_spin_rf_readout dut (
    .i_clk                     (i_clk),
    .i_rst                     (i_rst),
    .conf_sys_ctrl_reg_READOUT (readout),
    .conf_sys_ctrl_reg_RESET   (soft_reset),
    .conf_reg_total_run_count  (run_count),
    .final_spin_rf_q           (rf_q),
    .out_GPIO_ready            (gpio_ready),
    .final_spin_rf_a           (rf_a),
    .final_spin_rf_ceb         (rf_ceb),
    .out_GPIO                  (gpio),
    .out_GPIO_valid            (gpio_valid),
    .readout_done              (done),
    .readout_word_cnt          (word_cnt)
  );

  always #5 i_clk = ~i_clk;

  always @(posedge i_clk) begin
    if (!rf_ceb) rf_q <= rf_mem[rf_a];
  end

  always @(posedge i_clk) begin
    if (!rf_ceb) begin
      ceb_cnt <= ceb_cnt + 1;
      addr_q.push_back(rf_a);
    end
    if (gpio_valid) valid_cnt <= valid_cnt + 1;
    if (gpio_valid && gpio_ready) bytes_q.push_back(gpio);
    if (prev_stall && !(gpio_valid && gpio == prev_byte)) stall_err <= stall_err + 1;
    prev_stall <= gpio_valid && !gpio_ready;
    prev_byte  <= gpio;
  end

  task automatic wait_done(input int budget, output int cycles, output bit ok);
    ok = 1'b0;
    cycles = 0;
    for (int i = 0; i < budget; i++) begin
      @(negedge i_clk);
      cycles++;
      if (done) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic test_reset;
    i_rst = 1'b1; readout = 1'b0; soft_reset = 1'b0; run_count = 8'd0; gpio_ready = 1'b1;
    repeat (2) @(negedge i_clk);
    i_rst = 1'b0;
    @(negedge i_clk);
    checks++; if (gpio !== 8'h00) begin errors++; $display("FAIL rst_gpio got %h exp 00", gpio); end
    checks++; if (gpio_valid !== 1'b0) begin errors++; $display("FAIL rst_valid got %b exp 0", gpio_valid); end
    checks++; if (rf_ceb !== 1'b1) begin errors++; $display("FAIL rst_ceb got %b exp 1", rf_ceb); end
    checks++; if (rf_a !== 7'd0) begin errors++; $display("FAIL rst_addr got %0d exp 0", rf_a); end
    checks++; if (done !== 1'b0) begin errors++; $display("FAIL rst_done got %b exp 0", done); end
    checks++; if (word_cnt !== 8'd0) begin errors++; $display("FAIL rst_cnt got %0d exp 0", word_cnt); end
  endtask

  task automatic test_basic;
    logic [7:0] exp_b [$];
    int b0, c0, cyc;
    bit ok;
`ifdef READOUT_CHECKSUM_EN
    exp_b = '{8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'h03, 8'h03,
              8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h01, 8'h01};
`else
    exp_b = '{8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'h03,
              8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h01};
`endif
    rf_mem[0] = 50'h3_FFFF_FFFF_FFFF;
    rf_mem[1] = 50'h0_0000_0000_0001;
    run_count = 8'd2; gpio_ready = 1'b1;
    b0 = bytes_q.size(); c0 = ceb_cnt;
    readout = 1'b1;
    @(negedge i_clk);
    checks++; if (rf_ceb !== 1'b0 || rf_a !== 7'd0) begin errors++; $display("FAIL t1_rd_cycle got ceb=%b a=%0d exp ceb=0 a=0", rf_ceb, rf_a); end
    @(negedge i_clk);
    checks++; if (rf_ceb !== 1'b1 || gpio_valid !== 1'b0) begin errors++; $display("FAIL t1_cap_cycle got ceb=%b valid=%b exp 1 0", rf_ceb, gpio_valid); end
    @(negedge i_clk);
    checks++; if (gpio_valid !== 1'b1 || gpio !== 8'hFF) begin errors++; $display("FAIL t1_first_byte got valid=%b byte=%h exp 1 FF", gpio_valid, gpio); end
    wait_done(100, cyc, ok);
    checks++; if (!ok || (cyc + 3) != 1 + 2 * (2 + BPW)) begin errors++; $display("FAIL t1_done_cycle got ok=%0d cycle=%0d exp %0d", ok, cyc + 3, 1 + 2 * (2 + BPW)); end
    checks++; if (bytes_q.size() - b0 != exp_b.size()) begin errors++; $display("FAIL t1_byte_count got %0d exp %0d", bytes_q.size() - b0, exp_b.size()); end
    for (int i = 0; i < exp_b.size() && b0 + i < bytes_q.size(); i++) begin
      checks++; if (bytes_q[b0 + i] !== exp_b[i]) begin errors++; $display("FAIL t1_byte%0d got %h exp %h", i, bytes_q[b0 + i], exp_b[i]); end
    end
    checks++; if (word_cnt !== 8'd2) begin errors++; $display("FAIL t1_cnt got %0d exp 2", word_cnt); end
    checks++; if (ceb_cnt - c0 != 2) begin errors++; $display("FAIL t1_ceb_pulses got %0d exp 2", ceb_cnt - c0); end
    readout = 1'b0;
    @(negedge i_clk);
    checks++; if (done !== 1'b0 || word_cnt !== 8'd0) begin errors++; $display("FAIL t1_ack got done=%b cnt=%0d exp 0 0", done, word_cnt); end
  endtask

  task automatic test_backpressure;
    logic [7:0] exp_b [$];
    int b0, s0, cyc;
    bit ok;
    logic [3:0] pat;
`ifdef READOUT_CHECKSUM_EN
    exp_b = '{8'hAA, 8'hAA, 8'hAA, 8'hAA, 8'hAA, 8'hAA, 8'h02, 8'h02};
`else
    exp_b = '{8'hAA, 8'hAA, 8'hAA, 8'hAA, 8'hAA, 8'hAA, 8'h02};
`endif
    pat = 4'b1001;
    rf_mem[0] = 50'h2_AAAA_AAAA_AAAA;
    run_count = 8'd1;
    b0 = bytes_q.size(); s0 = stall_err;
    readout = 1'b1;
    ok = 1'b0; cyc = 0;
    for (int i = 0; i < 200; i++) begin
      gpio_ready = pat[3 - (i % 4)];
      @(negedge i_clk);
      if (done) begin ok = 1'b1; break; end
    end
    gpio_ready = 1'b1;
    checks++; if (!ok) begin errors++; $display("FAIL t2_timeout got done=%b exp 1", done); end
    checks++; if (bytes_q.size() - b0 != exp_b.size()) begin errors++; $display("FAIL t2_byte_count got %0d exp %0d", bytes_q.size() - b0, exp_b.size()); end
    for (int i = 0; i < exp_b.size() && b0 + i < bytes_q.size(); i++) begin
      checks++; if (bytes_q[b0 + i] !== exp_b[i]) begin errors++; $display("FAIL t2_byte%0d got %h exp %h", i, bytes_q[b0 + i], exp_b[i]); end
    end
    checks++; if (stall_err != s0) begin errors++; $display("FAIL t2_hold got %0d unstable stalls exp 0", stall_err - s0); end
    readout = 1'b0;
    @(negedge i_clk);
  endtask

  task automatic test_zero_count;
    int c0, v0;
    run_count = 8'd0;
    c0 = ceb_cnt; v0 = valid_cnt;
    readout = 1'b1;
    @(negedge i_clk);
    checks++; if (done !== 1'b1) begin errors++; $display("FAIL t3_done got %b exp 1", done); end
    repeat (3) @(negedge i_clk);
    checks++; if (ceb_cnt != c0 || valid_cnt != v0) begin errors++; $display("FAIL t3_quiet got ceb=%0d valid=%0d exp 0 0", ceb_cnt - c0, valid_cnt - v0); end
    readout = 1'b0;
    @(negedge i_clk);
    checks++; if (done !== 1'b0) begin errors++; $display("FAIL t3_ack got %b exp 0", done); end
  endtask

  task automatic test_abort;
    int b0, a0, cyc;
    bit ok;
    for (int i = 0; i < 3; i++) rf_mem[i] = 50'h1_2345_6789_ABC0 + 50'(i);
    run_count = 8'd3; gpio_ready = 1'b1;
    b0 = bytes_q.size();
    readout = 1'b1;
    ok = 1'b0;
    for (int i = 0; i < 100; i++) begin
      @(negedge i_clk);
      if (bytes_q.size() - b0 >= 10) begin ok = 1'b1; break; end
    end
    checks++; if (!ok || word_cnt !== 8'd1 || gpio_valid !== 1'b1) begin errors++; $display("FAIL t4_mid_word got ok=%0d cnt=%0d valid=%b exp 1 1 1", ok, word_cnt, gpio_valid); end
    readout = 1'b0;
    @(negedge i_clk);
    checks++; if (gpio_valid !== 1'b0 || word_cnt !== 8'd0 || rf_ceb !== 1'b1 || done !== 1'b0) begin
      errors++; $display("FAIL t4_abort got valid=%b cnt=%0d ceb=%b done=%b exp 0 0 1 0", gpio_valid, word_cnt, rf_ceb, done);
    end
    @(negedge i_clk);
    checks++; if (gpio_valid !== 1'b0 || rf_ceb !== 1'b1) begin errors++; $display("FAIL t4_idle got valid=%b ceb=%b exp 0 1", gpio_valid, rf_ceb); end
    a0 = addr_q.size();
    readout = 1'b1;
    @(negedge i_clk);
    checks++; if (rf_ceb !== 1'b0 || rf_a !== 7'd0) begin errors++; $display("FAIL t4_restart got ceb=%b a=%0d exp 0 0", rf_ceb, rf_a); end
    wait_done(100, cyc, ok);
    checks++; if (!ok || word_cnt !== 8'd3) begin errors++; $display("FAIL t4_complete got ok=%0d cnt=%0d exp 1 3", ok, word_cnt); end
    checks++; if (addr_q.size() - a0 != 3 || addr_q[a0] !== 7'd0 || addr_q[a0 + 2] !== 7'd2) begin
      errors++; $display("FAIL t4_addrs got n=%0d exp 3 addresses 0..2", addr_q.size() - a0);
    end
    readout = 1'b0;
    @(negedge i_clk);
  endtask

  task automatic test_soft_reset;
    bit ok;
    for (int i = 0; i < 8; i++) rf_mem[i] = 50'h0_F0F0_F0F0_F0F0 ^ 50'(i);
    run_count = 8'd8; gpio_ready = 1'b1;
    readout = 1'b1;
    ok = 1'b0;
    for (int i = 0; i < 200; i++) begin
      @(negedge i_clk);
      if (word_cnt == 8'd5 && gpio_valid) begin ok = 1'b1; break; end
    end
    checks++; if (!ok) begin errors++; $display("FAIL t5_reach_word5 got cnt=%0d exp 5 in send", word_cnt); end
    soft_reset = 1'b1;
    @(negedge i_clk);
    checks++; if ({gpio, gpio_valid, rf_ceb, rf_a, done, word_cnt} !== {8'h00, 1'b0, 1'b1, 7'd0, 1'b0, 8'd0}) begin
      errors++; $display("FAIL t5_soft_reset got gpio=%h v=%b ceb=%b a=%0d done=%b cnt=%0d exp 00 0 1 0 0 0", gpio, gpio_valid, rf_ceb, rf_a, done, word_cnt);
    end
    soft_reset = 1'b0;
    @(negedge i_clk);
    checks++; if (rf_ceb !== 1'b0 || rf_a !== 7'd0) begin errors++; $display("FAIL t5_restart got ceb=%b a=%0d exp 0 0", rf_ceb, rf_a); end
    i_rst = 1'b1;
    @(negedge i_clk);
    i_rst = 1'b0;
    readout = 1'b0;
    checks++; if ({gpio, gpio_valid, rf_ceb, rf_a, done, word_cnt} !== {8'h00, 1'b0, 1'b1, 7'd0, 1'b0, 8'd0}) begin
      errors++; $display("FAIL t5_hard_reset got gpio=%h v=%b ceb=%b a=%0d done=%b cnt=%0d exp 00 0 1 0 0 0", gpio, gpio_valid, rf_ceb, rf_a, done, word_cnt);
    end
    @(negedge i_clk);
  endtask

  task automatic test_saturate;
    int b0, a0, c0, cyc;
    bit ok, addr_ok;
    for (int i = 0; i < 128; i++) rf_mem[i] = 50'(i) * 50'h0_0101_0101_0101;
    run_count = 8'd200; gpio_ready = 1'b1;
    b0 = bytes_q.size(); a0 = addr_q.size(); c0 = ceb_cnt;
    readout = 1'b1;
    wait_done(128 * (2 + BPW) + 50, cyc, ok);
    checks++; if (!ok || word_cnt !== 8'd128) begin errors++; $display("FAIL t6_cnt got ok=%0d cnt=%0d exp 1 128", ok, word_cnt); end
    checks++; if (ceb_cnt - c0 != 128) begin errors++; $display("FAIL t6_ceb_pulses got %0d exp 128", ceb_cnt - c0); end
    addr_ok = (addr_q.size() - a0 == 128);
    for (int i = 0; i < 128 && addr_ok; i++) if (addr_q[a0 + i] !== 7'(i)) addr_ok = 1'b0;
    checks++; if (!addr_ok) begin errors++; $display("FAIL t6_addrs got n=%0d exp 128 ascending from 0", addr_q.size() - a0); end
    checks++; if (bytes_q.size() - b0 != 128 * BPW) begin errors++; $display("FAIL t6_bytes got %0d exp %0d", bytes_q.size() - b0, 128 * BPW); end
    readout = 1'b0;
    @(negedge i_clk);
  endtask

  initial begin
    test_reset();
    test_basic();
    test_backpressure();
    test_zero_count();
    test_abort();
    test_soft_reset();
    test_saturate();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
